// File: rtl/mul_pkg.sv
// Shared types and helpers for the multiplier library: FSM states, Booth digit
// encoding and the radix-4 digit count.
package mul_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    BD_ZERO,
    BD_P1,
    BD_P2,
    BD_M1,
    BD_M2
  } booth_digit_e;

  // Number of radix-4 digits for a W-bit operand extended to W+2 bits.
  function automatic int unsigned booth_num_digits(input int unsigned w);
    return (w + 2) / 2;
  endfunction

  // Map a 3-bit overlapping Booth window to its digit in {0, +1, +2, -1, -2}.
  function automatic booth_digit_e booth_decode(input logic [2:0] win);
    booth_digit_e d;
    case (win)
      3'b001, 3'b010: d = BD_P1;
      3'b011:         d = BD_P2;
      3'b100:         d = BD_M2;
      3'b101, 3'b110: d = BD_M1;
      default:        d = BD_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mul_booth_r4_pp.sv
// Radix-4 Booth partial product: decodes one Y window, scales the extended
// multiplicand by the digit and places it at the digit's bit position.
module mul_booth_r4_pp
  import mul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic        [2:0]                      y_win,
  input  logic        [DATA_WIDTH+1:0]           x_ext,
  input  logic        [$clog2(2*DATA_WIDTH)-1:0] shamt,
  output logic signed [2*DATA_WIDTH-1:0]         pp
);

  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned SE = PW - DATA_WIDTH - 2;

  booth_digit_e        dig;
  logic signed [PW-1:0] x_se;
  logic signed [PW-1:0] mag;

  // Digit-scaled multiplicand, sign-extended to the product width, then shifted.
  always_comb begin
    dig  = booth_decode(y_win);
    x_se = {{SE{x_ext[DATA_WIDTH+1]}}, x_ext};
    mag  = '0;
    case (dig)
      BD_P1:   mag = x_se;
      BD_P2:   mag = x_se <<< 1;
      BD_M1:   mag = -x_se;
      BD_M2:   mag = -(x_se <<< 1);
      default: mag = '0;
    endcase
    pp = mag <<< shamt;
  end

endmodule

// File: rtl/mul_booth_r4_seq.sv
// Sequential radix-4 Booth multiplier with valid/ready on both sides and a
// runtime signed/unsigned mode. One Booth digit is retired per CALC cycle.
// Optional MUL_BOOTH_EARLY_END_EN: leave CALC as soon as the remaining Y bits
// are all equal, since every remaining digit is then zero.
module mul_booth_r4_seq
  import mul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_vld,
  output logic                      o_rdy,
  input  logic                      i_sgn,
  input  logic [DATA_WIDTH-1:0]     i_num_x,
  input  logic [DATA_WIDTH-1:0]     i_num_y,
  output logic                      o_vld,
  input  logic                      i_rdy,
  output logic [2*DATA_WIDTH-1:0]   o_res,
  output logic                      o_busy
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned N    = booth_num_digits(W);
  localparam int unsigned CW   = $clog2(N + 1);
  localparam int unsigned SH_W = $clog2(2 * W);

  // Operand width must be even and at least 4.
  if ((W < 4) || ((W % 2) != 0)) begin : g_bad_width
    $error("mul_booth_r4_seq: DATA_WIDTH must be even and >= 4");
  end

  state_e                  state;
  logic [W+1:0]            x_q;
  logic [W+2:0]            y_q;
  logic [2*W-1:0]          acc_q;
  logic [CW-1:0]           cnt_q;
  logic [SH_W-1:0]         shamt_c;
  logic signed [2*W-1:0]   pp_c;
  logic                    early_c;
  logic [W+1:0]            x_ext_c;
  logic [W+1:0]            y_ext_c;

  assign x_ext_c = i_sgn ? {{2{i_num_x[W-1]}}, i_num_x} : {2'b00, i_num_x};
  assign y_ext_c = i_sgn ? {{2{i_num_y[W-1]}}, i_num_y} : {2'b00, i_num_y};
  assign shamt_c = SH_W'({cnt_q, 1'b0});

`ifdef MUL_BOOTH_EARLY_END_EN
  assign early_c = (&y_q) | ~(|y_q);
`else
  assign early_c = 1'b0;
`endif

  mul_booth_r4_pp #(
    .DATA_WIDTH (W)
  ) u_pp (
    .y_win (y_q[2:0]),
    .x_ext (x_q),
    .shamt (shamt_c),
    .pp    (pp_c)
  );

  // Control FSM with registered handshake outputs and the datapath registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= S_IDLE;
      o_rdy  <= 1'b1;
      o_vld  <= 1'b0;
      o_res  <= '0;
      o_busy <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_vld && o_rdy) begin
            x_q    <= x_ext_c;
            y_q    <= {y_ext_c, 1'b0};
            acc_q  <= '0;
            cnt_q  <= '0;
            o_rdy  <= 1'b0;
            o_busy <= 1'b1;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (early_c) begin
            state <= S_DONE;
          end else begin
            acc_q <= acc_q + pp_c;
            y_q   <= {{2{y_q[W+2]}}, y_q[W+2:2]};
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (!o_vld) begin
            o_vld <= 1'b1;
            o_res <= acc_q;
          end else if (i_rdy) begin
            o_vld  <= 1'b0;
            o_res  <= '0;
            o_rdy  <= 1'b1;
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          state  <= S_IDLE;
          o_rdy  <= 1'b1;
          o_vld  <= 1'b0;
          o_res  <= '0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_booth_r4_seq.sv
// Directed and random checks for mul_booth_r4_seq (DATA_WIDTH = 8).
module tb_mul_booth_r4_seq;

  localparam int unsigned W       = 8;
  localparam int unsigned N       = (W + 2) / 2;
  localparam int          LAT_MAX = 40;

  typedef struct {
    logic        s;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] p;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_vld;
  logic        in_rdy;
  logic        sgn;
  logic [7:0]  num_x;
  logic [7:0]  num_y;
  logic        out_vld;
  logic        out_rdy;
  logic [15:0] res;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  mul_booth_r4_seq #(.DATA_WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_vld   (in_vld),
    .o_rdy   (in_rdy),
    .i_sgn   (sgn),
    .i_num_x (num_x),
    .i_num_y (num_y),
    .o_vld   (out_vld),
    .i_rdy   (out_rdy),
    .o_res   (res),
    .o_busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected edges from handshake to o_vld high.
  function automatic int exp_lat(input logic s, input logic [7:0] y);
`ifdef MUL_BOOTH_EARLY_END_EN
    logic [10:0] yr;
    yr = {(s ? {2{y[7]}} : 2'b00), y, 1'b0};
    for (int i = 0; i < int'(N); i++) begin
      if ((&yr) || !(|yr)) return i + 2;
      yr = {{2{yr[10]}}, yr[10:2]};
    end
    return int'(N) + 1;
`else
    return int'(N) + 1;
`endif
  endfunction

  function automatic logic [15:0] ref_mul(input logic s, input logic [7:0] x, input logic [7:0] y);
    int a;
    int b;
    a = s ? int'($signed(x)) : int'(x);
    b = s ? int'($signed(y)) : int'(y);
    return 16'(a * b);
  endfunction

  task automatic start(input string tag, input logic s, input logic [7:0] x, input logic [7:0] y);
    check({tag, "_rdy"}, 32'(in_rdy), 32'd1);
    sgn    = s;
    num_x  = x;
    num_y  = y;
    in_vld = 1'b1;
    step();
    in_vld = 1'b0;
  endtask

  task automatic wait_vld(output int lat);
    lat = 0;
    while (!out_vld && lat < LAT_MAX) begin
      step();
      lat++;
    end
  endtask

  task automatic run_mul(input string tag, input logic s, input logic [7:0] x, input logic [7:0] y,
                         input logic [15:0] exp);
    int lat;
    start(tag, s, x, y);
    wait_vld(lat);
    check({tag, "_vld"}, 32'(out_vld), 32'd1);
    check({tag, "_res"}, 32'(res), 32'(exp));
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat(s, y)));
    step();
    check({tag, "_done"}, {30'd0, out_vld, in_rdy}, 32'b01);
  endtask

  vec_t vecs[$];

  initial begin
    int lat;
    logic [7:0] rx;
    logic [7:0] ry;

    rst_n   = 1'b0;
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    sgn     = 1'b0;
    num_x   = '0;
    num_y   = '0;
    step();
    step();
    check("rst_rdy",  32'(in_rdy),  32'd1);
    check("rst_vld",  32'(out_vld), 32'd0);
    check("rst_res",  32'(res),     32'd0);
    check("rst_busy", 32'(busy),    32'd0);
    rst_n = 1'b1;
    step();

    vecs.push_back('{1'b1, 8'h80, 8'h80, 16'h4000});
    vecs.push_back('{1'b0, 8'hFF, 8'hFF, 16'hFE01});
    vecs.push_back('{1'b1, 8'hFF, 8'hFF, 16'h0001});
    vecs.push_back('{1'b1, 8'h7F, 8'h80, 16'hC080});
    vecs.push_back('{1'b1, 8'hFF, 8'h01, 16'hFFFF});
    vecs.push_back('{1'b0, 8'h55, 8'h00, 16'h0000});
    vecs.push_back('{1'b0, 8'h55, 8'h01, 16'h0055});
    vecs.push_back('{1'b0, 8'h03, 8'h05, 16'h000F});
    vecs.push_back('{1'b1, 8'h80, 8'h7F, 16'hC080});
    vecs.push_back('{1'b0, 8'h80, 8'h80, 16'h4000});
    foreach (vecs[i]) run_mul($sformatf("dir%0d", i), vecs[i].s, vecs[i].x, vecs[i].y, vecs[i].p);

    // Back-pressure: result held, new operands ignored while DONE.
    out_rdy = 1'b0;
    start("bp", 1'b1, 8'h7F, 8'h80);
    wait_vld(lat);
    check("bp_vld", 32'(out_vld), 32'd1);
    for (int i = 0; i < 10; i++) begin
      sgn    = 1'b0;
      num_x  = 8'(i + 1);
      num_y  = 8'h11;
      in_vld = 1'b1;
      step();
      check("bp_hold_vld", 32'(out_vld), 32'd1);
      check("bp_hold_res", 32'(res),     32'hC080);
      check("bp_hold_rdy", 32'(in_rdy),  32'd0);
    end
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    step();
    check("bp_rel_vld", 32'(out_vld), 32'd0);
    check("bp_rel_rdy", 32'(in_rdy),  32'd1);
    check("bp_rel_res", 32'(res),     32'd0);

    // Reset during the third CALC cycle aborts the operation.
    start("rst_mid", 1'b0, 8'hFF, 8'hFF);
    step();
    step();
    check("calc_busy", 32'(busy),    32'd1);
    check("calc_vld",  32'(out_vld), 32'd0);
    check("calc_res",  32'(res),     32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_vld",  32'(out_vld), 32'd0);
    check("abort_res",  32'(res),     32'd0);
    check("abort_rdy",  32'(in_rdy),  32'd1);
    check("abort_busy", 32'(busy),    32'd0);
    run_mul("post_rst", 1'b0, 8'd3, 8'd5, 16'h000F);

    // Random pairs in both modes against the reference product.
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 1000; i++) begin
        rx = 8'($urandom());
        ry = 8'($urandom());
        if (i < 4) ry = (i[0]) ? 8'hFF : 8'h00;
        run_mul(m == 1 ? "rnd_s" : "rnd_u", m == 1, rx, ry, ref_mul(m == 1, rx, ry));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
